// File: rtl/tt_mux_rr_scheduler_if.sv
// Request/data and grant/mux signals shared between the pin-side logic and the
// round-robin scheduler.
interface tt_mux_rr_scheduler_if;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       data_out;
    logic       busy;

    modport master (
        output req, data_in,
        input  sel, grant, valid, data_out, busy
    );

    modport slave (
        input  req, data_in,
        output sel, grant, valid, data_out, busy
    );
endinterface

// File: rtl/tt_mux_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 single-bit mux between four requesters,
// with bounded burst length and a mandatory dead cycle after every grant.
//
// state   | meaning
// IDLE    | no grant, arbitrating when ena = 1
// GRANT   | requester sel owns the mux, hold_cnt counts burst cycles
// GAP     | one dead cycle after a release, then back to IDLE
module tt_mux_rr_scheduler #(
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    tt_mux_rr_scheduler_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (!ena) begin
            state_d = S_IDLE;
            hold_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        state_d = S_GRANT;
                        sel_d   = win_idx;
                        hold_d  = 4'd0;
                    end
                end
                S_GRANT: begin
                    if (!bus.req[sel_q] || (hold_q == HOLD_LAST)) begin
                        state_d = S_GAP;
                        ptr_d   = sel_q + 2'd1;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d  = hold_q + 4'd1;
                    end
                end
                S_GAP:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        grant_d = (state_d == S_GRANT) ? (4'b0001 << sel_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 4'd0;
            grant_q <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant    = grant_q;
    assign bus.valid    = (state_q == S_GRANT);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.data_out = (state_q == S_GRANT) ? bus.data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_tt_mux_rr_scheduler.sv
// Scoreboard bench for the round-robin mux scheduler; three instances with
// MAX_HOLD = 8, 2 and 1 share the same stimulus.
module tb_tt_mux_rr_scheduler;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] d;
        logic       e;
        logic       rn;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] data_in = 4'd0;

    int checks = 0;
    int failures = 0;

    stim_t      stim_q[$];
    logic [8:0] exp_q[$];

    tt_mux_rr_scheduler_if ifa();
    tt_mux_rr_scheduler_if ifb();
    tt_mux_rr_scheduler_if ifc();

    assign ifa.req = req;
    assign ifa.data_in = data_in;
    assign ifb.req = req;
    assign ifb.data_in = data_in;
    assign ifc.req = req;
    assign ifc.data_in = data_in;

    tt_mux_rr_scheduler #(.MAX_HOLD(8)) dut_a (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifa.slave));
    tt_mux_rr_scheduler #(.MAX_HOLD(2)) dut_b (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifb.slave));
    tt_mux_rr_scheduler #(.MAX_HOLD(1)) dut_c (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifc.slave));

    always #5 clk = ~clk;

    // Observed vector layout: {grant, sel, valid, busy, data_out}
    function automatic logic [8:0] obs(input int k);
        case (k)
            0:       return {ifa.grant, ifa.sel, ifa.valid, ifa.busy, ifa.data_out};
            1:       return {ifb.grant, ifb.sel, ifb.valid, ifb.busy, ifb.data_out};
            default: return {ifc.grant, ifc.sel, ifc.valid, ifc.busy, ifc.data_out};
        endcase
    endfunction

    function automatic logic [8:0] ev(input logic [3:0] g, input logic [1:0] s,
                                      input logic b, input logic dout);
        return {g, s, (g != 4'd0), b, dout};
    endfunction

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic e, input logic rn,
                       input logic [3:0] g, input logic [1:0] s, input logic b, input logic dout);
        stim_q.push_back('{r: r, d: d, e: e, rn: rn});
        exp_q.push_back(ev(g, s, b, dout));
    endtask

    task automatic apply(input stim_t st);
        req = st.r;
        data_in = st.d;
        ena = st.e;
        rst_n = st.rn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'd0;
        data_in = 4'd0;
        ena = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        add(4'b1111, 4'b0000, 1, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 4'b0000, 1, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== e) begin
                    failures++;
                    $display("FAIL reset cyc=%0d dut=%0d got=%b exp=%b", cyc, k, obs(k), e);
                end
            end
            cyc++;
        end
    endtask

    task automatic test_single_request();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        do_reset();
        add(4'b0100, 4'b0100, 1, 1, 4'b0100, 2'd2, 1, 1);
        add(4'b0100, 4'b0000, 1, 1, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd2, 1, 0);
        add(4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd2, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== e) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs(0), e);
            end
            cyc++;
        end
    endtask

    task automatic test_hold_limit();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        do_reset();
        for (int i = 0; i < 8; i++) add(4'b0001, 4'b0001, 1, 1, 4'b0001, 2'd0, 1, 1);
        add(4'b0001, 4'b0001, 1, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0001, 4'b0001, 1, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b0001, 4'b0001, 1, 1, 4'b0001, 2'd0, 1, 1);
        add(4'b0000, 4'b0001, 1, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0000, 4'b0001, 1, 1, 4'b0000, 2'd0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== e) begin
                failures++;
                $display("FAIL hold_limit cyc=%0d got=%b exp=%b", cyc, obs(0), e);
            end
            cyc++;
        end
    endtask

    task automatic test_fairness_wrap();
        stim_t st;
        logic [8:0] e;
        logic [3:0] dat = 4'b1010;
        int cyc = 0;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            add(4'b1111, dat, 1, 1, 4'(1 << s), 2'(s), 1, dat[s]);
            add(4'b1111, dat, 1, 1, 4'(1 << s), 2'(s), 1, dat[s]);
            add(4'b1111, dat, 1, 1, 4'b0000, 2'(s), 1, 0);
            add(4'b1111, dat, 1, 1, 4'b0000, 2'(s), 0, 0);
        end
        add(4'b1111, dat, 1, 1, 4'b0001, 2'd0, 1, dat[0]);
        add(4'b1111, dat, 1, 1, 4'b0001, 2'd0, 1, dat[0]);
        add(4'b0000, dat, 1, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0000, dat, 1, 1, 4'b0000, 2'd0, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(1) !== e) begin
                failures++;
                $display("FAIL fairness cyc=%0d got=%b exp=%b", cyc, obs(1), e);
            end
            cyc++;
        end
    endtask

    task automatic test_simultaneous_release();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        do_reset();
        add(4'b0010, 4'b0000, 1, 1, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b0000, 1, 1, 4'b0010, 2'd1, 1, 0);
        add(4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd1, 1, 0);
        add(4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd1, 0, 0);
        add(4'b1111, 4'b0000, 1, 1, 4'b0100, 2'd2, 1, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(1) !== e) begin
                failures++;
                $display("FAIL simul_release cyc=%0d got=%b exp=%b", cyc, obs(1), e);
            end
            cyc++;
        end
    endtask

    task automatic test_max_hold_one();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        do_reset();
        add(4'b0001, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1);
        add(4'b0001, 4'b1111, 1, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0001, 4'b1111, 1, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b0001, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1);
        add(4'b0001, 4'b1111, 1, 1, 4'b0000, 2'd0, 1, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(2) !== e) begin
                failures++;
                $display("FAIL max_hold_one cyc=%0d got=%b exp=%b", cyc, obs(2), e);
            end
            cyc++;
        end
    endtask

    task automatic test_ena_drop();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        do_reset();
        add(4'b1000, 4'b1000, 1, 1, 4'b1000, 2'd3, 1, 1);
        add(4'b1000, 4'b1000, 1, 1, 4'b1000, 2'd3, 1, 1);
        add(4'b1000, 4'b1000, 0, 1, 4'b0000, 2'd3, 0, 0);
        add(4'b1000, 4'b1000, 0, 1, 4'b0000, 2'd3, 0, 0);
        add(4'b1111, 4'b1000, 1, 1, 4'b0001, 2'd0, 1, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== e) begin
                failures++;
                $display("FAIL ena_drop cyc=%0d got=%b exp=%b", cyc, obs(0), e);
            end
            cyc++;
        end
    endtask

    task automatic test_mid_burst_reset();
        stim_t st;
        logic [8:0] e;
        int cyc = 0;
        do_reset();
        add(4'b0001, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1);
        add(4'b0000, 4'b1111, 1, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0000, 4'b1111, 1, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b0100, 4'b1111, 1, 1, 4'b0100, 2'd2, 1, 1);
        add(4'b0100, 4'b1111, 1, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            apply(st);
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== e) begin
                failures++;
                $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, obs(0), e);
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_hold_limit();
        test_fairness_wrap();
        test_simultaneous_release();
        test_max_hold_one();
        test_ena_drop();
        test_mid_burst_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_mux_rr_scheduler.md
Name: tt_mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 4:1 single-bit mux channel between four requesters.
- Arbitrates requests and drives the registered mux select.
- Holds each grant for a bounded burst, then rotates priority.
- Sits between the ui_in request/data pins and uo_out in the tile top level.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles per grant; legal range 1..16; hold counter is 4 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  design enable; low forces release and an idle state.
- req  input  4  request per requester; level-sensitive; bit i is requester i.
- data_in  input  4  data bit per requester; mux input i.
- sel  output  2  registered mux select, index of the current or last grantee.
- grant  output  4  registered one-hot grant; all zero when no grant is active.
- valid  output  1  high exactly when the state is GRANT.
- data_out  output  1  data_in[sel] when valid = 1, else 0; combinational from registered sel/valid.
- busy  output  1  high in GRANT or GAP.

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = IDLE, sel = 0, grant = 0, valid = 0, busy = 0, data_out = 0, ptr = 0, hold_cnt = 0. Reset mid-GRANT drops grant on that edge with no GAP cycle.
- States: IDLE, GRANT, GAP; 2-bit state register.
- IDLE, ena = 1, req != 0:
  - Winner is the first set req bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: state = GRANT, sel = winner, grant = one-hot(winner), hold_cnt = 0.
  - Latency: req sampled high at edge N gives grant/valid visible after edge N+1 (1 cycle).
- IDLE, req = 0: remain IDLE; outputs unchanged except grant/valid held at 0.
- GRANT:
  - Each cycle in which req[sel] = 1 and hold_cnt < MAX_HOLD-1: hold_cnt += 1, stay in GRANT.
  - Release condition: req[sel] = 0 or hold_cnt = MAX_HOLD-1. Both true in the same cycle counts as one release.
  - On release, next edge: state = GAP, grant = 0, ptr = (sel+1) mod 4 (2-bit wrap; sel 3 gives ptr 0), hold_cnt = 0.
  - Requests from non-granted requesters are ignored during GRANT; no preemption.
- GAP: one mandatory idle cycle (grant = 0, valid = 0, busy = 1). Next edge goes to IDLE unconditionally.
  - Minimum spacing between consecutive grants is therefore 2 dead cycles.
- sel keeps its last value in GAP and IDLE; data_out is forced to 0 whenever valid = 0.
- MAX_HOLD = 1: every grant lasts exactly 1 cycle.
- ena = 0 in any state: next edge state = IDLE, grant = 0, hold_cnt = 0. ptr and sel are retained; no GAP cycle is inserted. Arbitration in IDLE requires ena = 1.
- Invariants:
  - grant is one-hot or zero.
  - valid = |grant.
  - grant[sel] = valid.

Test Plan:
- Reset/idle: hold rst_n = 0 for 2 cycles with req = 4'b1111, then release with req = 0 → sel = 0, grant = 0, valid = 0, busy = 0, data_out = 0.
- Single request: req = 4'b0100, data_in = 4'b0100 at edge N → grant = 4'b0100, sel = 2, valid = 1, data_out = 1 after N+1. Drop req at edge M → grant = 0, busy = 1 after M+1; busy = 0 after M+2.
- Hold limit: MAX_HOLD = 8, req = 4'b0001 held constant → grant[0] high for exactly 8 cycles, then GAP, then IDLE, then regranted to requester 0 (ptr = 1 but only req[0] is set).
- Round-robin fairness with wrap: req = 4'b1111 held, MAX_HOLD = 2 → grant order 0, 1, 2, 3, 0. Each grant lasts 2 cycles with 2 dead cycles between grants; ptr wraps 3 → 0.
- Simultaneous release: req[sel] deasserts in the same cycle hold_cnt reaches MAX_HOLD-1 → single GAP cycle, ptr advances by exactly 1.
- ena and mid-burst reset: deassert ena mid-GRANT → grant = 0 next cycle, sel unchanged, no GAP. Separately, assert rst_n = 0 mid-GRANT → all outputs are at reset values on the next edge and ptr = 0.
